// File: rtl/ram_stream_reader_if.sv
// Command, RAM port B and output stream signals of ram_stream_reader.
// slave is the reader's view; master is the view of whoever drives commands and the RAM.
interface ram_stream_reader_if #(
    parameter int unsigned DEPTH = 2048,
    parameter int unsigned WIDTH = 8
) ();
    localparam int unsigned DEPTH_BITS = $clog2(DEPTH);

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [DEPTH_BITS-1:0] cmd_addr;
    logic [DEPTH_BITS:0]   cmd_len;
    logic [DEPTH_BITS-1:0] ram_address_b;
    logic [WIDTH-1:0]      ram_q_b;
    logic                  out_valid;
    logic                  out_ready;
    logic [WIDTH-1:0]      out_data;
    logic                  out_last;

    modport slave (
        input  cmd_valid, cmd_addr, cmd_len, ram_q_b, out_ready,
        output cmd_ready, ram_address_b, out_valid, out_data, out_last
    );

    modport master (
        output cmd_valid, cmd_addr, cmd_len, ram_q_b, out_ready,
        input  cmd_ready, ram_address_b, out_valid, out_data, out_last
    );
endinterface

// File: rtl/ram_stream_reader.sv
// Sequential reader for a RAM read port with 1-cycle latency, streaming words
// through a 4-entry FIFO onto a valid/ready output with a last marker.
module ram_stream_reader #(
    parameter int unsigned DEPTH = 2048,
    parameter int unsigned WIDTH = 8
) (
    input  logic               clock,
    input  logic               reset,
    ram_stream_reader_if.slave bus,
    output logic               busy
);
    localparam int unsigned DEPTH_BITS = $clog2(DEPTH);
    localparam logic [DEPTH_BITS:0]   LenOne  = {{DEPTH_BITS{1'b0}}, 1'b1};
    localparam logic [DEPTH_BITS-1:0] AddrOne = {{(DEPTH_BITS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e                state_q, state_d;
    logic [DEPTH_BITS-1:0] addr_q, addr_d;
    logic [DEPTH_BITS:0]   remaining_q, remaining_d;
    logic                  issue, issue_last;
    logic                  issue_q, issue_last_q;
    logic [WIDTH-1:0]      fifo_data_q [4];
    logic [3:0]            fifo_last_q;
    logic [1:0]            rd_ptr_q, wr_ptr_q;
    logic [2:0]            count_q;
    logic                  push, pop, head_valid, head_last;

    assign head_valid = (count_q != 3'd0);
    assign head_last  = fifo_last_q[rd_ptr_q];
    assign pop        = head_valid && bus.out_ready;
    // The read issued last cycle returns data now; it lands in the FIFO this edge.
    assign push       = issue_q;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        // Count the in-flight read so the FIFO can never overflow.
        issue       = (state_q == StRun) && ((count_q + {2'b00, issue_q}) < 3'd4);
        issue_last  = issue && (remaining_q == LenOne);
        case (state_q)
            StIdle: begin
                if (bus.cmd_valid) begin
                    addr_d      = bus.cmd_addr;
                    remaining_d = bus.cmd_len;
                    if (bus.cmd_len != '0) begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                if (issue) begin
                    addr_d      = addr_q + AddrOne;
                    remaining_d = remaining_q - LenOne;
                    if (issue_last) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (pop && head_last) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            remaining_q  <= '0;
            issue_q      <= 1'b0;
            issue_last_q <= 1'b0;
            fifo_last_q  <= '0;
            rd_ptr_q     <= 2'd0;
            wr_ptr_q     <= 2'd0;
            count_q      <= 3'd0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            remaining_q  <= remaining_d;
            issue_q      <= issue;
            issue_last_q <= issue_last;
            if (push) begin
                fifo_last_q[wr_ptr_q] <= issue_last_q;
                wr_ptr_q              <= wr_ptr_q + 2'd1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 3'd1;
                2'b01:   count_q <= count_q - 3'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && push) begin
            fifo_data_q[wr_ptr_q] <= bus.ram_q_b;
        end
    end

    assign bus.cmd_ready     = (state_q == StIdle);
    assign bus.ram_address_b = addr_q;
    assign bus.out_valid     = head_valid;
    assign bus.out_data      = head_valid ? fifo_data_q[rd_ptr_q] : '0;
    assign bus.out_last      = head_valid && head_last;
    assign busy              = (state_q != StIdle);
endmodule

// File: tb/tb_ram_stream_reader.sv
// Self-checking bench for ram_stream_reader: a 2048-deep instance for most scenarios
// and a 16-deep instance for wrap-around, each fed by a behavioural 1-cycle-latency RAM.
module tb_ram_stream_reader;
    localparam int unsigned DEPTH  = 2048;
    localparam int unsigned SDEPTH = 16;
    localparam int unsigned WIDTH  = 8;
    localparam int unsigned DB     = 11;
    localparam int unsigned SDB    = 4;

    typedef logic [DB-1:0]  addr_t;
    typedef logic [DB:0]    len_t;
    typedef logic [SDB-1:0] saddr_t;
    typedef logic [SDB:0]   slen_t;

    logic clock = 1'b0;
    logic reset;
    logic busy, sbusy;
    always #5 clock = ~clock;

    ram_stream_reader_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();
    ram_stream_reader_if #(.DEPTH(SDEPTH), .WIDTH(WIDTH)) sbus ();

    ram_stream_reader #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clock(clock), .reset(reset), .bus(bus.slave), .busy(busy)
    );
    ram_stream_reader #(.DEPTH(SDEPTH), .WIDTH(WIDTH)) sdut (
        .clock(clock), .reset(reset), .bus(sbus.slave), .busy(sbusy)
    );

    logic [WIDTH-1:0] mem  [DEPTH];
    logic [WIDTH-1:0] smem [SDEPTH];

    always @(posedge clock) bus.ram_q_b  <= mem[bus.ram_address_b];
    always @(posedge clock) sbus.ram_q_b <= smem[sbus.ram_address_b];

    int vectors = 0;
    int errors  = 0;

    always @(negedge clock) begin
        vectors++;
        if (dut.count_q > 3'd4 || sdut.count_q > 3'd4) begin
            errors++;
            $display("FAIL fifo_count got %0d/%0d want <=4", dut.count_q, sdut.count_q);
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0; bus.out_ready = 1'b0;
        sbus.cmd_valid = 1'b0; sbus.cmd_addr = '0; sbus.cmd_len = '0; sbus.out_ready = 1'b0;
        repeat (2) @(negedge clock);
        vectors++;
        if ({bus.cmd_ready, bus.out_valid, bus.out_last, busy, bus.ram_address_b, bus.out_data}
            !== {4'b1000, addr_t'(0), 8'h00}) begin
            errors++;
            $display("FAIL reset_state got %b %b %b %b %h %h want 1 0 0 0 000 00", bus.cmd_ready,
                     bus.out_valid, bus.out_last, busy, bus.ram_address_b, bus.out_data);
        end
        vectors++;
        if ({sbus.cmd_ready, sbus.out_valid, sbusy, sbus.ram_address_b} !== {3'b100, 4'h0}) begin
            errors++;
            $display("FAIL reset_small got %b %b %b %h want 1 0 0 0", sbus.cmd_ready,
                     sbus.out_valid, sbusy, sbus.ram_address_b);
        end
        reset = 1'b0;
    endtask

    // Cycle-accurate check of the first-word latency and end-of-command timing.
    task automatic test_latency();
        logic exp_v, exp_l, exp_r, exp_b;
        logic [WIDTH-1:0] exp_d;
        @(negedge clock);
        bus.cmd_valid = 1'b1; bus.cmd_addr = addr_t'(5); bus.cmd_len = len_t'(4);
        bus.out_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            exp_v = (k >= 3 && k <= 6);
            exp_d = exp_v ? WIDTH'(5 + k - 3) : 8'h00;
            exp_l = (k == 6);
            exp_r = (k >= 7);
            exp_b = (k <= 6);
            vectors++;
            if ({bus.out_valid, bus.out_data, bus.out_last, bus.cmd_ready, busy}
                !== {exp_v, exp_d, exp_l, exp_r, exp_b}) begin
                errors++;
                $display("FAIL latency cyc%0d got v%b d%h l%b r%b b%b want v%b d%h l%b r%b b%b", k,
                         bus.out_valid, bus.out_data, bus.out_last, bus.cmd_ready, busy,
                         exp_v, exp_d, exp_l, exp_r, exp_b);
            end
            if (k == 1) begin
                vectors++;
                if (bus.ram_address_b !== addr_t'(5)) begin
                    errors++;
                    $display("FAIL first_addr got %h want 005", bus.ram_address_b);
                end
            end
            bus.cmd_valid = 1'b0;
        end
    endtask

    // mode 0: ready held high, 1: random ready, 2: random ready with a 10-cycle hold-low.
    task automatic stream_cmd(input int addr, input int len, input int mode);
        logic [WIDTH-1:0] exp_d [$];
        bit               exp_l [$];
        int               got = 0;
        int               cyc = 0;
        bit               pv = 0, pr = 0, r;
        logic [WIDTH-1:0] pd = '0;
        logic             pl = 1'b0;
        for (int k = 0; k < len; k++) begin
            exp_d.push_back(mem[(addr + k) % DEPTH]);
            exp_l.push_back(k == len - 1);
        end
        @(negedge clock);
        vectors++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL stream_ready_before got %b want 1", bus.cmd_ready);
        end
        bus.cmd_valid = 1'b1; bus.cmd_addr = addr_t'(addr); bus.cmd_len = len_t'(len);
        bus.out_ready = 1'b1;
        while (got < len && cyc < len * 8 + 50) begin
            @(negedge clock);
            cyc++;
            bus.cmd_valid = 1'b0;
            if (pv && !pr) begin
                vectors++;
                if ({bus.out_valid, bus.out_data, bus.out_last} !== {1'b1, pd, pl}) begin
                    errors++;
                    $display("FAIL stall_hold got v%b d%h l%b want v1 d%h l%b", bus.out_valid,
                             bus.out_data, bus.out_last, pd, pl);
                end
            end
            if (mode == 0) begin
                r = 1'b1;
                vectors++;
                if (bus.out_valid !== (cyc >= 3)) begin
                    errors++;
                    $display("FAIL no_bubble cyc%0d got %b want %b", cyc, bus.out_valid, cyc >= 3);
                end
            end else if (mode == 2 && cyc >= 3 && cyc < 13) begin
                r = 1'b0;
            end else begin
                r = ($urandom % 4) != 0;
            end
            bus.out_ready = r;
            if (bus.out_valid && r) begin
                vectors++;
                if ({bus.out_data, bus.out_last} !== {exp_d[got], exp_l[got]}) begin
                    errors++;
                    $display("FAIL stream_word %0d got %h/%b want %h/%b", got, bus.out_data,
                             bus.out_last, exp_d[got], exp_l[got]);
                end
                got++;
            end
            pv = bus.out_valid; pr = r; pd = bus.out_data; pl = bus.out_last;
        end
        vectors++;
        if (got != len) begin
            errors++;
            $display("FAIL stream_timeout got %0d words want %0d", got, len);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            vectors++;
            if ({bus.out_valid, busy, bus.cmd_ready} !== 3'b001) begin
                errors++;
                $display("FAIL stream_idle got v%b b%b r%b want v0 b0 r1", bus.out_valid, busy,
                         bus.cmd_ready);
            end
        end
        bus.out_ready = 1'b1;
    endtask

    task automatic test_random();
        for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'($urandom);
        stream_cmd($urandom_range(0, DEPTH - 1), 8, 2);
        stream_cmd(2046, 4, 0);
        for (int i = 0; i < 5; i++) stream_cmd($urandom_range(0, DEPTH - 1), $urandom_range(1, 40), 1);
        stream_cmd(2040, DEPTH + 5, 0);
    endtask

    task automatic test_len_zero();
        @(negedge clock);
        bus.cmd_valid = 1'b1; bus.cmd_addr = addr_t'(7); bus.cmd_len = len_t'(0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            bus.cmd_valid = 1'b0;
            vectors++;
            if ({bus.cmd_ready, busy, bus.out_valid} !== 3'b100) begin
                errors++;
                $display("FAIL len_zero cyc%0d got r%b b%b v%b want r1 b0 v0", k, bus.cmd_ready,
                         busy, bus.out_valid);
            end
        end
    endtask

    task automatic test_reset_mid();
        int got = 0;
        int cyc = 0;
        @(negedge clock);
        bus.cmd_valid = 1'b1; bus.cmd_addr = addr_t'(50); bus.cmd_len = len_t'(8);
        bus.out_ready = 1'b1;
        while (got < 3 && cyc < 40) begin
            @(negedge clock);
            cyc++;
            bus.cmd_valid = 1'b0;
            if (bus.out_valid) got++;
        end
        reset = 1'b1;
        @(negedge clock);
        vectors++;
        if ({bus.out_valid, busy, bus.cmd_ready, bus.out_last, bus.ram_address_b}
            !== {4'b0010, addr_t'(0)} || got != 3) begin
            errors++;
            $display("FAIL reset_mid got v%b b%b r%b l%b a%h n%0d want v0 b0 r1 l0 a000 n3",
                     bus.out_valid, busy, bus.cmd_ready, bus.out_last, bus.ram_address_b, got);
        end
        reset = 1'b0;
        stream_cmd(0, 2, 0);
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] exp_d [$];
        bit               exp_l [$];
        bit               last_hs = 0, accepted = 0;
        int               got = 0, cyc = 0;
        for (int k = 0; k < 3; k++) begin exp_d.push_back(mem[20 + k]); exp_l.push_back(k == 2); end
        for (int k = 0; k < 2; k++) begin exp_d.push_back(mem[100 + k]); exp_l.push_back(k == 1); end
        @(negedge clock);
        bus.cmd_valid = 1'b1; bus.cmd_addr = addr_t'(20); bus.cmd_len = len_t'(3);
        bus.out_ready = 1'b1;
        @(negedge clock);
        bus.cmd_addr = addr_t'(100); bus.cmd_len = len_t'(2);
        while (got < 5 && cyc < 60) begin
            @(negedge clock);
            cyc++;
            if (!accepted) begin
                vectors++;
                if (bus.cmd_ready !== last_hs) begin
                    errors++;
                    $display("FAIL b2b_accept cyc%0d got %b want %b", cyc, bus.cmd_ready, last_hs);
                end
                if (bus.cmd_ready) accepted = 1;
            end else begin
                bus.cmd_valid = 1'b0;
            end
            last_hs = 0;
            if (bus.out_valid) begin
                vectors++;
                if ({bus.out_data, bus.out_last} !== {exp_d[got], exp_l[got]}) begin
                    errors++;
                    $display("FAIL b2b_word %0d got %h/%b want %h/%b", got, bus.out_data,
                             bus.out_last, exp_d[got], exp_l[got]);
                end
                last_hs = bus.out_last;
                got++;
            end
        end
        bus.cmd_valid = 1'b0;
        vectors++;
        if (got != 5 || !accepted) begin
            errors++;
            $display("FAIL b2b_timeout got %0d words acc %0b want 5 acc 1", got, accepted);
        end
        @(negedge clock);
        vectors++;
        if ({bus.out_valid, busy} !== 2'b00) begin
            errors++;
            $display("FAIL b2b_idle got v%b b%b want v0 b0", bus.out_valid, busy);
        end
    endtask

    task automatic test_wrap16();
        logic exp_v, exp_l;
        logic [WIDTH-1:0] exp_d;
        int got = 0, cyc = 0;
        @(negedge clock);
        sbus.cmd_valid = 1'b1; sbus.cmd_addr = saddr_t'(14); sbus.cmd_len = slen_t'(4);
        sbus.out_ready = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clock);
            sbus.cmd_valid = 1'b0;
            exp_v = (k >= 3 && k <= 6);
            exp_d = exp_v ? smem[(14 + k - 3) % SDEPTH] : 8'h00;
            exp_l = (k == 6);
            vectors++;
            if ({sbus.out_valid, sbus.out_data, sbus.out_last} !== {exp_v, exp_d, exp_l}) begin
                errors++;
                $display("FAIL wrap16 cyc%0d got v%b d%h l%b want v%b d%h l%b", k, sbus.out_valid,
                         sbus.out_data, sbus.out_last, exp_v, exp_d, exp_l);
            end
        end
        // Length beyond the RAM depth: addresses keep wrapping, count is exact.
        sbus.cmd_valid = 1'b1; sbus.cmd_addr = saddr_t'(3); sbus.cmd_len = slen_t'(20);
        while (got < 20 && cyc < 80) begin
            @(negedge clock);
            cyc++;
            sbus.cmd_valid = 1'b0;
            sbus.out_ready = ($urandom % 3) != 0;
            if (sbus.out_valid && sbus.out_ready) begin
                vectors++;
                if ({sbus.out_data, sbus.out_last} !== {smem[(3 + got) % SDEPTH], got == 19}) begin
                    errors++;
                    $display("FAIL wrap16_long %0d got %h/%b want %h/%b", got, sbus.out_data,
                             sbus.out_last, smem[(3 + got) % SDEPTH], got == 19);
                end
                got++;
            end
        end
        @(negedge clock);
        vectors++;
        if (got != 20 || {sbus.out_valid, sbusy, sbus.cmd_ready} !== 3'b001) begin
            errors++;
            $display("FAIL wrap16_end got n%0d v%b b%b r%b want n20 v0 b0 r1", got,
                     sbus.out_valid, sbusy, sbus.cmd_ready);
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = WIDTH'(i);
        for (int i = 0; i < SDEPTH; i++) smem[i] = WIDTH'(8'h30 + i);
        test_reset();
        test_latency();
        test_wrap16();
        test_len_zero();
        test_random();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
